// File: rtl/spram_multiport_if.sv
// Request/response bundle between memory clients and spram_multiport.
// Per-port fields are flattened; port p owns slice [p*W +: W].
interface spram_multiport_if #(
    parameter int NUM_PORTS = 2,
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 32
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            req_wren;
    logic [NUM_PORTS*AWIDTH-1:0]     req_addr;
    logic [NUM_PORTS*DWIDTH/8-1:0]   req_byteen;
    logic [NUM_PORTS*DWIDTH-1:0]     req_data;
    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [DWIDTH-1:0]               rsp_data;

    // client side
    modport master (
        output req_valid, req_wren, req_addr, req_byteen, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    // memory side
    modport slave (
        input  req_valid, req_wren, req_addr, req_byteen, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/spram_multiport.sv
// Multi-port scratch RAM: NUM_PORTS clients share one word array through a
// round-robin arbiter. Writes use per-byte enables; reads return tagged
// responses after RD_LATENCY cycles on a shared data bus.
module spram_multiport #(
    parameter int AWIDTH     = 10,
    parameter int NUM_WORDS  = 1024,
    parameter int DWIDTH     = 32,
    parameter int NUM_PORTS  = 2,
    parameter int RD_LATENCY = 1,
    parameter     INIT_FILE  = ""
) (
    input  logic               clk,
    input  logic               resetn,
    spram_multiport_if.slave   bus
);
    localparam int BW = DWIDTH / 8;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // storage has no reset: contents survive resetn
    logic [DWIDTH-1:0] mem_q [NUM_WORDS];

    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic [NUM_PORTS-1:0] gnt_vec;

    logic                 sel_wren;
    logic [AWIDTH-1:0]    sel_addr;
    logic [BW-1:0]        sel_be;
    logic [DWIDTH-1:0]    sel_data;
    logic                 sel_inrange;
    logic                 rd_go;

    // read pipeline: stage 1 captures the array, later stages just delay
    logic [RD_LATENCY:1]             vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY:1][PW-1:0]     port_pipe_q, port_pipe_d;
    logic [RD_LATENCY:1][DWIDTH-1:0] data_pipe_q, data_pipe_d;

    // round-robin pick: first valid port at or after the pointer, wrapping
    always_comb begin
        int p;
        p       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            p = (int'(rr_ptr_q) + k) % NUM_PORTS;
            if (!gnt_any && bus.req_valid[p]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(p);
            end
        end
        if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
        bus.req_ready = gnt_vec;
    end

    // mux the winning port's request fields and advance the pointer past it
    always_comb begin
        sel_wren    = bus.req_wren[gnt_idx];
        sel_addr    = bus.req_addr[int'(gnt_idx)*AWIDTH +: AWIDTH];
        sel_be      = bus.req_byteen[int'(gnt_idx)*BW +: BW];
        sel_data    = bus.req_data[int'(gnt_idx)*DWIDTH +: DWIDTH];
        sel_inrange = {{(32-AWIDTH){1'b0}}, sel_addr} < 32'(NUM_WORDS);
        rd_go       = gnt_any && !sel_wren;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_any)
            rr_ptr_d = (int'(gnt_idx) == NUM_PORTS-1) ? '0 : gnt_idx + PW'(1);
    end

    // pipeline next state; data/port stages only load behind a valid so the
    // output holds its last value between responses
    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        port_pipe_d    = port_pipe_q;
        data_pipe_d    = data_pipe_q;
        vld_pipe_d[1]  = rd_go;
        if (rd_go) begin
            port_pipe_d[1] = gnt_idx;
            data_pipe_d[1] = sel_inrange ? mem_q[sel_addr] : '0;
        end
        for (int s = 2; s <= RD_LATENCY; s++) begin
            vld_pipe_d[s] = vld_pipe_q[s-1];
            if (vld_pipe_q[s-1]) begin
                port_pipe_d[s] = port_pipe_q[s-1];
                data_pipe_d[s] = data_pipe_q[s-1];
            end
        end
    end

    // pointer and read pipeline registers; reset drops in-flight reads
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q    <= '0;
            vld_pipe_q  <= '0;
            port_pipe_q <= '0;
            data_pipe_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            vld_pipe_q  <= vld_pipe_d;
            port_pipe_q <= port_pipe_d;
            data_pipe_q <= data_pipe_d;
        end
    end

    // byte-masked array write; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (gnt_any && sel_wren && sel_inrange) begin
            for (int b = 0; b < BW; b++)
                if (sel_be[b]) mem_q[sel_addr][8*b +: 8] <= sel_data[8*b +: 8];
        end
    end

    // decode the last stage's port tag into the per-port response strobe
    always_comb begin
        bus.rsp_data = data_pipe_q[RD_LATENCY];
        for (int p = 0; p < NUM_PORTS; p++)
            bus.rsp_valid[p] = vld_pipe_q[RD_LATENCY] &&
                               (port_pipe_q[RD_LATENCY] == PW'(p));
    end
endmodule
